wb_rr_arbiter: RTL and testbench

Round-robin Wishbone B3 bus arbiter that shares one downstream Wishbone slave port (typically the input of a slave-decode arbiter) between NUM_MASTERS requesting masters. A grant is held for the whole time the granted master keeps cyc asserted, so bursts and read-modify-write sequences are never split. An optional watchdog aborts stalled transfers with an error. The block sits between CPU/debug/DMA masters and the system data-bus decoder.

---
 rtl/wb_rr_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone B3 arbiter sharing one slave port between NUM_MASTERS masters
//
// Ports:
//   wb_clk, wb_rst_n            bus clock (rising edge), asynchronous active-low reset
//   wbm_*_o (in)                per-master request slices, master i at [i*W +: W]
//   wbm_dat_i (out)             slave read data, broadcast to every master
//   wbm_ack_i/err_i/rty_i (out) per-master responses, only the granted master sees them
//   wbs_*_i (out)               muxed request towards the shared slave
//   wbs_dat_o/ack_o/err_o/rty_o slave response
//   grant (out)                 registered one-hot grant, 0 when idle
//
// Optional feature: define WB_RR_ARB_WATCHDOG_EN to abort transfers the slave
// leaves unanswered for TIMEOUT cycles with a one-cycle error to the master.

module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst_n,
    input  logic [NUM_MASTERS*AW-1:0] wbm_adr_o,
    input  logic [NUM_MASTERS*DW-1:0] wbm_dat_o,
    input  logic [NUM_MASTERS*4-1:0]  wbm_sel_o,
    input  logic [NUM_MASTERS-1:0]    wbm_we_o,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_o,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_o,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_o,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_o,
    output logic [DW-1:0]             wbm_dat_i,
    output logic [NUM_MASTERS-1:0]    wbm_ack_i,
    output logic [NUM_MASTERS-1:0]    wbm_err_i,
    output logic [NUM_MASTERS-1:0]    wbm_rty_i,
    output logic [AW-1:0]             wbs_adr_i,
    output logic [DW-1:0]             wbs_dat_i,
    output logic [3:0]                wbs_sel_i,
    output logic                      wbs_we_i,
    output logic                      wbs_cyc_i,
    output logic                      wbs_stb_i,
    output logic [2:0]                wbs_cti_i,
    output logic [1:0]                wbs_bte_i,
    input  logic [DW-1:0]             wbs_dat_o,
    input  logic                      wbs_ack_o,
    input  logic                      wbs_err_o,
    input  logic                      wbs_rty_o,
    output logic [NUM_MASTERS-1:0]    grant
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
        $error("wb_rr_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT 1..65535");
    end

`ifdef WB_RR_ARB_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE, GRANT, ERR, ABORT} state_t;
`else
    typedef enum logic [0:0] {IDLE, GRANT} state_t;
`endif

    state_t                 state, next_state;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [IW-1:0]          last, last_nxt;
    logic [IW-1:0]          scan_idx, pick_idx;
    logic                   pick_valid;
    logic                   gnt_cyc, gnt_stb;

`ifdef WB_RR_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt, wd_cnt_nxt;
    logic        slave_resp;
    assign slave_resp = wbs_ack_o | wbs_err_o | wbs_rty_o;
`endif

    assign gnt_cyc   = |(wbm_cyc_o & grant);
    assign gnt_stb   = |(wbm_stb_o & grant);
    assign wbm_dat_i = wbs_dat_o;

    // Scan downward from last+NUM_MASTERS to last+1 so the last hit, i.e. the
    // nearest requester after the previous owner, wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last;
        scan_idx   = last;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            scan_idx = IW'((int'(last) + k) % NUM_MASTERS);
            if (wbm_cyc_o[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            last   <= IW'(NUM_MASTERS - 1);
`ifdef WB_RR_ARB_WATCHDOG_EN
            wd_cnt <= '0;
`endif
        end else begin
            state  <= next_state;
            grant  <= grant_nxt;
            last   <= last_nxt;
`ifdef WB_RR_ARB_WATCHDOG_EN
            wd_cnt <= wd_cnt_nxt;
`endif
        end
    end

    always_comb begin
        next_state = state;
        grant_nxt  = grant;
        last_nxt   = last;
`ifdef WB_RR_ARB_WATCHDOG_EN
        wd_cnt_nxt = wd_cnt;
`endif
        case (state)
            IDLE: begin
`ifdef WB_RR_ARB_WATCHDOG_EN
                wd_cnt_nxt = '0;
`endif
                if (pick_valid) begin
                    next_state          = GRANT;
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    last_nxt            = pick_idx;
                end
            end
            GRANT: begin
`ifdef WB_RR_ARB_WATCHDOG_EN
                if (slave_resp) begin
                    wd_cnt_nxt = '0;
                end else if (gnt_stb) begin
                    wd_cnt_nxt = wd_cnt + 16'd1;
                end
`endif
                if (!gnt_cyc) begin
                    next_state = IDLE;
                    grant_nxt  = '0;
                end
`ifdef WB_RR_ARB_WATCHDOG_EN
                else if (wd_cnt == 16'(TIMEOUT) && !slave_resp) begin
                    next_state = ERR;
                end
`endif
            end
`ifdef WB_RR_ARB_WATCHDOG_EN
            ERR: begin
                next_state = ABORT;
            end
            ABORT: begin
                // Slave stays isolated until the owner gives up the cycle.
                if (!gnt_cyc) begin
                    next_state = IDLE;
                    grant_nxt  = '0;
                end
            end
`endif
            default: begin
                next_state = IDLE;
                grant_nxt  = '0;
            end
        endcase
    end

    // Request mux and response routing; everything is quiet outside GRANT so a
    // late slave response during error recovery never reaches a master.
    always_comb begin
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        wbs_sel_i = '0;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cti_i = '0;
        wbs_bte_i = '0;
        wbm_ack_i = '0;
        wbm_err_i = '0;
        wbm_rty_i = '0;
        if (state == GRANT) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant[i]) begin
                    wbs_adr_i = wbm_adr_o[i*AW +: AW];
                    wbs_dat_i = wbm_dat_o[i*DW +: DW];
                    wbs_sel_i = wbm_sel_o[i*4 +: 4];
                    wbs_we_i  = wbm_we_o[i];
                    wbs_cyc_i = wbm_cyc_o[i];
                    wbs_stb_i = wbm_stb_o[i];
                    wbs_cti_i = wbm_cti_o[i*3 +: 3];
                    wbs_bte_i = wbm_bte_o[i*2 +: 2];
                end
            end
            wbm_ack_i = grant & {NUM_MASTERS{wbs_ack_o}};
            wbm_err_i = grant & {NUM_MASTERS{wbs_err_o}};
            wbm_rty_i = grant & {NUM_MASTERS{wbs_rty_o}};
        end
`ifdef WB_RR_ARB_WATCHDOG_EN
        if (state == ERR) begin
            wbm_err_i = grant;
        end
`endif
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - scoreboard bench for wb_rr_arbiter with four masters

module tb_wb_rr_arbiter;

    localparam int N = 4;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic            wb_clk = 1'b0;
    logic            wb_rst_n;
    logic [N*32-1:0] m_adr;
    logic [N*32-1:0] m_dat;
    logic [N*4-1:0]  m_sel;
    logic [N-1:0]    m_we, m_cyc, m_stb;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [31:0]     wbm_dat_i;
    logic [N-1:0]    wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic [31:0]     wbs_adr_i, wbs_dat_i;
    logic [3:0]      wbs_sel_i;
    logic            wbs_we_i, wbs_cyc_i, wbs_stb_i;
    logic [2:0]      wbs_cti_i;
    logic [1:0]      wbs_bte_i;
    logic [31:0]     wbs_dat_o;
    logic            s_ack, s_err;
    logic [N-1:0]    grant;

    logic            slv_err_mode, slv_hang;
    int              wcnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int          id;
        bit          err;
        logic [31:0] data;
    } resp_t;

    resp_t        sq[$];
    int           gq[$];
    logic [N-1:0] prev_grant;

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(32), .DW(32), .TIMEOUT(16)) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .wbm_adr_o (m_adr),
        .wbm_dat_o (m_dat),
        .wbm_sel_o (m_sel),
        .wbm_we_o  (m_we),
        .wbm_cyc_o (m_cyc),
        .wbm_stb_o (m_stb),
        .wbm_cti_o (m_cti),
        .wbm_bte_o (m_bte),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .wbm_rty_i (wbm_rty_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cti_i (wbs_cti_i),
        .wbs_bte_i (wbs_bte_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (s_ack),
        .wbs_err_o (s_err),
        .wbs_rty_o (1'b0),
        .grant     (grant)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Slave: read data derived from the address, response two cycles after stb.
    assign wbs_dat_o = wbs_adr_i ^ KEY;

    always @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            wcnt  <= 0;
        end else if (wbs_cyc_i && wbs_stb_i && !s_ack && !s_err && !slv_hang) begin
            if (wcnt == 1) begin
                wcnt <= 0;
                if (slv_err_mode) s_err <= 1'b1;
                else              s_ack <= 1'b1;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            wcnt  <= 0;
        end
    end

    // Scoreboard monitor: grant order, dead cycle between owners, response routing.
    always @(negedge wb_clk) begin
        if (!wb_rst_n) begin
            prev_grant = grant;
        end else begin
            if (grant !== prev_grant) begin
                chk("dead_cycle", 32'(prev_grant == '0 || grant == '0), 32'd1);
                if (grant != '0) begin
                    chk("grant_q_nonempty", 32'(gq.size() != 0), 32'd1);
                    if (gq.size() != 0) chk("grant_order", 32'(grant), 32'd1 << gq.pop_front());
                end
            end
            prev_grant = grant;
            if ((wbm_ack_i | wbm_err_i) != '0) begin
                chk("resp_q_nonempty", 32'(sq.size() != 0), 32'd1);
                if (sq.size() != 0) begin
                    resp_t e;
                    e = sq.pop_front();
                    chk("resp_master", 32'(wbm_ack_i | wbm_err_i), 32'd1 << e.id);
                    chk("resp_kind", 32'(wbm_err_i != '0), 32'(e.err));
                    if (!e.err) chk("resp_data", wbm_dat_i, e.data);
                end
            end
        end
    end

    task automatic master_xfer(input int m, input logic [31:0] adr, input int beats,
                               input int hold, input logic exp_cyc_hold);
        logic [31:0] a;
        bit          got_err;
        bit          ok;
        got_err = 1'b0;
        m_sel[m*4 +: 4]   = 4'(m + 1);
        m_dat[m*32 +: 32] = 32'hC0DE_0000 + 32'(m);
        m_we[m]  = 1'b0;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        for (int b = 0; b < beats; b++) begin
            a = adr + 32'(4 * b);
            m_adr[m*32 +: 32] = a;
            m_cti[m*3 +: 3]   = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge wb_clk);
                if (wbm_ack_i[m] || wbm_err_i[m]) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("resp_timeout", 32'(ok), 32'd1);
            if (ok && wbs_cyc_i) begin
                chk("mux_adr", wbs_adr_i, a);
                chk("mux_sel", 32'(wbs_sel_i), 32'(m + 1));
                chk("mux_dat", wbs_dat_i, 32'hC0DE_0000 + 32'(m));
                chk("mux_we_bte", 32'({wbs_we_i, wbs_bte_i}), 32'd0);
                if (beats > 1 && b == beats - 1) chk("burst_cti", 32'(wbs_cti_i), 32'd7);
            end
            got_err = wbm_err_i[m];
            @(posedge wb_clk);
            #1;
            if (got_err || !ok) break;
        end
        m_stb[m] = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge wb_clk);
            chk("hold_grant", 32'(grant[m]), 32'd1);
            chk("hold_wbs_cyc", 32'(wbs_cyc_i), 32'(exp_cyc_hold));
            @(posedge wb_clk);
            #1;
        end
        m_cyc[m] = 1'b0;
        m_cti[m*3 +: 3] = 3'b000;
    endtask

    task automatic settle();
        repeat (3) @(posedge wb_clk);
        #1;
    endtask

    initial begin
        int n;
        bit ok;
        wb_rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
        m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
        slv_err_mode = 1'b0;
        slv_hang     = 1'b0;
        prev_grant   = '0;

        // Reset state
        repeat (3) @(posedge wb_clk);
        @(negedge wb_clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_wbs_cyc_stb", 32'({wbs_cyc_i, wbs_stb_i}), 32'd0);
        chk("rst_resp", 32'(wbm_ack_i | wbm_err_i | wbm_rty_i), 32'd0);
        @(posedge wb_clk);
        #1;
        wb_rst_n = 1'b1;
        settle();

        // Single master 2 read, grant one cycle after cyc
        gq.push_back(2);
        sq.push_back('{id: 2, err: 1'b0, data: 32'hDEAD_BEEF});
        fork
            master_xfer(2, 32'hDEAD_BEEF ^ KEY, 1, 0, 1'b0);
            begin
                @(posedge wb_clk);
                @(negedge wb_clk);
                chk("arb_latency_grant", 32'(grant), 32'h4);
                chk("arb_latency_cyc", 32'(wbs_cyc_i), 32'd1);
            end
        join
        settle();

        // All four masters at once after reset: order 0,1,2,3
        wb_rst_n = 1'b0;
        @(posedge wb_clk);
        #1;
        wb_rst_n = 1'b1;
        for (int m = 0; m < N; m++) begin
            gq.push_back(m);
            sq.push_back('{id: m, err: 1'b0, data: (32'h0000_1000 + 32'(m * 256)) ^ KEY});
        end
        fork
            master_xfer(0, 32'h0000_1000, 1, 0, 1'b0);
            master_xfer(1, 32'h0000_1100, 1, 0, 1'b0);
            master_xfer(2, 32'h0000_1200, 1, 0, 1'b0);
            master_xfer(3, 32'h0000_1300, 1, 0, 1'b0);
        join
        settle();

        // Master 1 eight-beat burst while master 0 waits
        gq.push_back(1);
        gq.push_back(0);
        for (int b = 0; b < 8; b++)
            sq.push_back('{id: 1, err: 1'b0, data: (32'h0000_2000 + 32'(4 * b)) ^ KEY});
        sq.push_back('{id: 0, err: 1'b0, data: 32'h0000_3000 ^ KEY});
        fork
            begin
                master_xfer(1, 32'h0000_2000, 8, 0, 1'b0);
                @(negedge wb_clk);
                chk("burst_release_hold", 32'(grant), 32'h2);
                @(negedge wb_clk);
                chk("burst_dead_cycle", 32'(grant), 32'h0);
                @(negedge wb_clk);
                chk("burst_next_owner", 32'(grant), 32'h1);
            end
            begin
                repeat (2) @(posedge wb_clk);
                #1;
                master_xfer(0, 32'h0000_3000, 1, 0, 1'b0);
            end
        join
        settle();

        // Slave error on master 3: routed only to master 3, grant held until cyc drops
        slv_err_mode = 1'b1;
        gq.push_back(3);
        sq.push_back('{id: 3, err: 1'b1, data: 32'h0});
        master_xfer(3, 32'h0000_4000, 1, 2, 1'b1);
        slv_err_mode = 1'b0;
        settle();

`ifdef WB_RR_ARB_WATCHDOG_EN
        // Watchdog: silent slave, error pulse 17 cycles after stb, slave isolated until release
        slv_hang = 1'b1;
        gq.push_back(1);
        gq.push_back(2);
        sq.push_back('{id: 1, err: 1'b1, data: 32'h0});
        sq.push_back('{id: 2, err: 1'b0, data: 32'h0000_6000 ^ KEY});
        fork
            master_xfer(1, 32'h0000_5000, 1, 3, 1'b0);
            begin
                ok = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge wb_clk);
                    if (wbs_stb_i) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk("wd_stb_seen", 32'(ok), 32'd1);
                n = 0;
                while (!wbm_err_i[1] && n < 100) begin
                    @(negedge wb_clk);
                    n++;
                end
                chk("wd_latency", 32'(n), 32'd17);
                chk("wd_err_cyc_low", 32'(wbs_cyc_i), 32'd0);
                slv_hang = 1'b0;
            end
            begin
                repeat (2) @(posedge wb_clk);
                #1;
                master_xfer(2, 32'h0000_6000, 1, 0, 1'b0);
            end
        join
        settle();
`endif

        // Asynchronous reset in the middle of a grant
        slv_hang = 1'b1;
        gq.push_back(0);
        m_adr[31:0] = 32'h0000_7000;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge wb_clk);
            if (grant[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_rst_granted", 32'(ok), 32'd1);
        #2;
        wb_rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_wbs_cyc_stb", 32'({wbs_cyc_i, wbs_stb_i}), 32'd0);
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(posedge wb_clk);
        #1;
        wb_rst_n = 1'b1;
        slv_hang = 1'b0;
        settle();

        chk("resp_q_drained", 32'(sq.size()), 32'd0);
        chk("grant_q_drained", 32'(gq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
